maint_scheduler: RTL and testbench

- Parametrised, multi-channel periodic maintenance scheduler for the SoftMC datapath. It generalises the fixed periodic-read, ZQ and refresh timers into NUM_CH identical channels.
- Each channel has a runtime-programmable interval, an enable and a mode bit, and a postponement (debt) counter.
- A fixed-priority arbiter issues one maintenance sequence at a time to the instruction sequencer, using the maint_req/maint_ack/softmc_fin handshake.

---
 rtl/maint_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_maint_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maint_scheduler.sv
// Multi-channel periodic maintenance scheduler: per-channel interval timers feed saturating
// debt counters, and a fixed-priority arbiter (channel 0 first) serves them one sequence at a time.
module maint_scheduler #(
    parameter int NUM_CH      = 3,
    parameter int TCK_PS      = 1500,
    parameter int CLK_RATIO   = 4,
    parameter int PRESCALE_PS = 500000,
    parameter int TIMER_W     = 20,
    parameter int MAX_PEND    = 8,
    parameter int PEND_W      = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_calib_complete,
    input  logic                     program_process,
    input  logic                     cfg_valid,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic                     cfg_enable,
    input  logic                     cfg_mode,
    input  logic [TIMER_W-1:0]       cfg_interval,
    output logic                     maint_req,
    input  logic                     maint_ack,
    input  logic                     softmc_fin,
    output logic [NUM_CH-1:0]        maint_init,
    output logic [CH_W-1:0]          maint_ch,
    output logic                     maint_process,
    output logic [NUM_CH*PEND_W-1:0] pending_cnt,
    output logic [NUM_CH-1:0]        overflow
);

    localparam int DIV_RAW = PRESCALE_PS / (TCK_PS * CLK_RATIO);
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int PRE_W   = $clog2(DIV + 1);
    localparam logic [PRE_W-1:0]  DIV_V = PRE_W'(DIV);
    localparam logic [PEND_W-1:0] MAX_V = PEND_W'(MAX_PEND);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               state;
    logic [PRE_W-1:0]     prescale;
    logic                 tick;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    ch_mode;
    logic [TIMER_W-1:0]   interval [NUM_CH];
    logic [TIMER_W-1:0]   timer    [NUM_CH];
    logic [PEND_W-1:0]    pend     [NUM_CH];

    logic [NUM_CH-1:0]    wr_hit;
    logic [NUM_CH-1:0]    hold;
    logic [NUM_CH-1:0]    expire;
    logic [NUM_CH-1:0]    busy_hit;
    logic [NUM_CH-1:0]    fin_hit;
    logic [NUM_CH-1:0]    pend_nz;
    logic [CH_W-1:0]      grant_ch;
    logic [NUM_CH-1:0]    grant_oh;
    logic                 grant;

    always_comb begin
        tick     = init_calib_complete && (prescale == PRE_W'(1));
        wr_hit   = '0;
        hold     = '0;
        expire   = '0;
        busy_hit = '0;
        fin_hit  = '0;
        pend_nz  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]   = cfg_valid && (cfg_ch == CH_W'(i));
            // mode 0 channels freeze while the user program owns the bus
            hold[i]     = !ch_en[i] || !init_calib_complete || (!ch_mode[i] && program_process);
            expire[i]   = tick && !wr_hit[i] && !hold[i] && (timer[i] == TIMER_W'(1));
            busy_hit[i] = (state == S_BUSY) && (maint_ch == CH_W'(i));
            fin_hit[i]  = softmc_fin && busy_hit[i];
            pend_nz[i]  = (pend[i] != '0);
        end
    end

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        grant_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_nz[i]) begin
                grant_ch = CH_W'(i);
            end
        end
        grant_oh  = NUM_CH'(1) << grant_ch;
        maint_req = (state == S_IDLE) && (|pend_nz);
        grant     = maint_req && maint_ack && !softmc_fin;
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pending_cnt[i*PEND_W +: PEND_W] = pend[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= DIV_V;
        end else if (!init_calib_complete || (prescale == PRE_W'(1))) begin
            prescale <= DIV_V;
        end else begin
            prescale <= prescale - PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_en   <= '0;
            ch_mode <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                interval[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    ch_en[i]    <= cfg_enable;
                    ch_mode[i]  <= cfg_mode;
                    interval[i] <= cfg_interval;
                end
            end
        end
    end

    // A timer at 0 (interval 0) neither decrements nor expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    timer[i] <= cfg_interval;
                end else if (hold[i]) begin
                    timer[i] <= interval[i];
                end else if (tick) begin
                    if (timer[i] == TIMER_W'(1)) begin
                        timer[i] <= interval[i];
                    end else if (timer[i] > TIMER_W'(1)) begin
                        timer[i] <= timer[i] - TIMER_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    overflow[i] <= 1'b0;
                end
                // Clearing spares the unit currently being served so its fin still has something to retire.
                if (!ch_en[i] || !init_calib_complete) begin
                    pend[i] <= (busy_hit[i] && pend_nz[i] && !fin_hit[i]) ? PEND_W'(1) : '0;
                end else if (expire[i] && !fin_hit[i]) begin
                    if (pend[i] == MAX_V) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        pend[i] <= pend[i] + PEND_W'(1);
                    end
                end else if (fin_hit[i] && !expire[i] && pend_nz[i]) begin
                    pend[i] <= pend[i] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            maint_ch      <= '0;
            maint_init    <= '0;
            maint_process <= 1'b0;
        end else begin
            maint_init <= '0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state         <= S_BUSY;
                        maint_ch      <= grant_ch;
                        maint_init    <= grant_oh;
                        maint_process <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (softmc_fin) begin
                        state         <= S_IDLE;
                        maint_process <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maint_scheduler.sv
// Bench for maint_scheduler: directed scenarios plus random traffic, every cycle compared
// against a tick-counting reference model of the scheduling rules.
module tb_maint_scheduler;

    localparam int NUM_CH   = 3;
    localparam int CH_W     = 2;
    localparam int TIMER_W  = 20;
    localparam int PEND_W   = 4;
    localparam int MAX_PEND = 8;
    localparam int DIV      = 4;

    logic clk = 1'b0;
    logic rst;
    logic calib;
    logic prog;
    logic cfg_valid;
    logic [CH_W-1:0] cfg_ch;
    logic cfg_enable;
    logic cfg_mode;
    logic [TIMER_W-1:0] cfg_interval;
    logic maint_req;
    logic maint_ack;
    logic softmc_fin;
    logic [NUM_CH-1:0] maint_init;
    logic [CH_W-1:0] maint_ch;
    logic maint_process;
    logic [NUM_CH*PEND_W-1:0] pending_cnt;
    logic [NUM_CH-1:0] overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int m_pend[NUM_CH];
    bit m_ovf[NUM_CH];
    bit m_en[NUM_CH];
    bit m_mode[NUM_CH];
    int m_ival[NUM_CH];
    int m_elapsed[NUM_CH];
    int m_calib_cycles;
    bit m_busy;
    int m_ch;
    int m_init;

    maint_scheduler #(.PRESCALE_PS(24000)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(calib), .program_process(prog),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_interval(cfg_interval), .maint_req(maint_req), .maint_ack(maint_ack),
        .softmc_fin(softmc_fin), .maint_init(maint_init), .maint_ch(maint_ch),
        .maint_process(maint_process), .pending_cnt(pending_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pend_of(input int ch);
        return int'(pending_cnt[ch*PEND_W +: PEND_W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_en[i] = 0; m_mode[i] = 0;
            m_ival[i] = 0; m_elapsed[i] = 0;
        end
        m_calib_cycles = 0; m_busy = 0; m_ch = 0; m_init = 0;
    endtask

    // Timers are modelled as "ticks seen since last (re)load"; expiry when that reaches the interval.
    task automatic model_step();
        bit tick, any_pre, wr, hold, exp_i, fin_i, busy_i;
        int gch, keep;
        tick = 0;
        if (calib) begin
            m_calib_cycles++;
            tick = (m_calib_cycles % DIV) == 0;
        end else begin
            m_calib_cycles = 0;
        end
        any_pre = 0; gch = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m_pend[i] > 0) begin any_pre = 1; gch = i; end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr     = cfg_valid && (int'(cfg_ch) == i);
            hold   = !m_en[i] || !calib || (!m_mode[i] && prog);
            busy_i = m_busy && (m_ch == i);
            fin_i  = softmc_fin && busy_i;
            exp_i  = 0;
            if (wr || hold) begin
                m_elapsed[i] = 0;
            end else if (tick && m_ival[i] != 0) begin
                m_elapsed[i]++;
                if (m_elapsed[i] == m_ival[i]) begin exp_i = 1; m_elapsed[i] = 0; end
            end
            if (!m_en[i] || !calib) begin
                keep = (busy_i && m_pend[i] > 0) ? 1 : 0;
                if (fin_i && keep > 0) keep--;
                m_pend[i] = keep;
            end else if (exp_i && !fin_i) begin
                if (m_pend[i] == MAX_PEND) m_ovf[i] = 1;
                else m_pend[i]++;
            end else if (fin_i && !exp_i && m_pend[i] > 0) begin
                m_pend[i]--;
            end
            if (wr) begin
                m_en[i] = cfg_enable; m_mode[i] = cfg_mode;
                m_ival[i] = int'(cfg_interval); m_ovf[i] = 0;
            end
        end
        m_init = 0;
        if (m_busy) begin
            if (softmc_fin) m_busy = 0;
        end else if (any_pre && maint_ack && !softmc_fin) begin
            m_busy = 1; m_ch = gch; m_init = 1 << gch;
        end
    endtask

    task automatic compare_all();
        int exp_pk, exp_ov;
        bit any;
        exp_pk = 0; exp_ov = 0; any = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_pk |= m_pend[i] << (i * PEND_W);
            exp_ov |= int'(m_ovf[i]) << i;
            if (m_pend[i] > 0) any = 1;
        end
        check("model_req", maint_req, !m_busy && any);
        check("model_init", maint_init, m_init);
        check("model_process", maint_process, m_busy);
        check("model_ch", maint_ch, m_ch);
        check("model_pending", pending_cnt, exp_pk);
        check("model_overflow", overflow, exp_ov);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic cfg_write(input int ch, input bit en, input bit mode, input int ival);
        cfg_valid = 1; cfg_ch = CH_W'(ch); cfg_enable = en; cfg_mode = mode;
        cfg_interval = TIMER_W'(ival);
        cycle();
        cfg_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1; maint_ack = 0; softmc_fin = 0; cfg_valid = 0; prog = 0; calib = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0, calib_off;
        cfg_ch = '0; cfg_enable = 0; cfg_mode = 0; cfg_interval = '0;
        do_reset();
        cycle();
        check("reset_req", maint_req, 0);
        check("reset_process", maint_process, 0);
        check("reset_pending", pending_cnt, 0);
        check("reset_overflow", overflow, 0);

        // Periodic expiry at DIV=4, interval=3
        repeat (3) cycle();
        cfg_write(0, 1, 1, 3);
        n = 0;
        while (!maint_req && n < 30) begin cycle(); n++; end
        check("t1_first_req_9_12", (n >= 9 && n <= 12), 1);
        t0 = cyc; n = 0;
        while (pend_of(0) < 2 && n < 30) begin cycle(); n++; end
        check("t1_period_a", cyc - t0, 12);
        t0 = cyc; n = 0;
        while (pend_of(0) < 3 && n < 30) begin cycle(); n++; end
        check("t1_period_b", cyc - t0, 12);

        // Priority between ch0 and ch2
        do_reset();
        cfg_write(2, 1, 1, 3);
        cfg_write(0, 1, 1, 3);
        n = 0;
        while (!(pend_of(0) != 0 && pend_of(2) != 0) && n < 40) begin cycle(); n++; end
        check("t2_both_pending", (pend_of(0) != 0 && pend_of(2) != 0), 1);
        maint_ack = 1; cycle(); maint_ack = 0;
        check("t2_init_ch0", maint_init, 3'b001);
        check("t2_ch0", maint_ch, 0);
        check("t2_req_low_busy", maint_req, 0);
        softmc_fin = 1; cycle(); softmc_fin = 0;
        check("t2_req_after_fin", maint_req, 1);
        maint_ack = 1; cycle(); maint_ack = 0;
        check("t2_init_ch2", maint_init, 3'b100);
        check("t2_ch2", maint_ch, 2);
        softmc_fin = 1; cycle(); softmc_fin = 0;

        // Saturation and overflow clear
        do_reset();
        cfg_write(1, 1, 1, 1);
        repeat (44) cycle();
        check("t3_pend_sat", pend_of(1), 8);
        check("t3_ovf_set", overflow[1], 1);
        cfg_write(1, 1, 1, 1);
        check("t3_ovf_cleared", overflow[1], 0);
        check("t3_pend_kept", pend_of(1), 8);

        // Mode 0 holds during program, mode 1 accumulates
        do_reset();
        prog = 1;
        cfg_write(0, 1, 0, 2);
        repeat (200) cycle();
        check("t4_mode0_no_debt", pend_of(0), 0);
        prog = 0; n = 0;
        while (!maint_req && n < 20) begin cycle(); n++; end
        check("t4_release_5_8", (n >= 5 && n <= 8), 1);
        do_reset();
        prog = 1;
        cfg_write(0, 1, 1, 2);
        repeat (200) cycle();
        check("t4_mode1_debt", pend_of(0), 8);
        prog = 0;

        // Expiry coinciding with fin; ack together with fin
        do_reset();
        cfg_write(0, 1, 1, 3);
        n = 0;
        while (!maint_req && n < 20) begin cycle(); n++; end
        maint_ack = 1; cycle(); maint_ack = 0;
        check("t5_busy", maint_process, 1);
        repeat (10) cycle();
        softmc_fin = 1; cycle(); softmc_fin = 0;
        check("t5_pend_held", pend_of(0), 1);
        check("t5_req_again", maint_req, 1);
        maint_ack = 1; cycle();
        softmc_fin = 1; cycle();
        maint_ack = 0; softmc_fin = 0;
        check("t5_ackfin_idle", maint_process, 0);
        check("t5_ackfin_no_init", maint_init, 0);

        // Asynchronous reset while busy
        do_reset();
        cfg_write(1, 1, 1, 1);
        repeat (44) cycle();
        maint_ack = 1; cycle(); maint_ack = 0;
        check("t6_busy_before_rst", maint_process, 1);
        #2 rst = 1;
        #1;
        check("t6_rst_process", maint_process, 0);
        check("t6_rst_req", maint_req, 0);
        check("t6_rst_pending", pending_cnt, 0);
        check("t6_rst_overflow", overflow, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        repeat (30) cycle();
        check("t6_no_req_after_rst", maint_req, 0);

        // Random traffic against the model
        calib_off = 0;
        for (int c = 0; c < 2500; c++) begin
            cfg_valid    = ($urandom_range(11) == 0);
            cfg_ch       = CH_W'($urandom_range(3));
            cfg_enable   = ($urandom_range(3) != 0);
            cfg_mode     = 1'($urandom_range(1));
            cfg_interval = TIMER_W'($urandom_range(5));
            if ($urandom_range(24) == 0) prog = ~prog;
            if (calib_off > 0) begin
                calib_off--;
                calib = (calib_off == 0);
            end else if ($urandom_range(149) == 0) begin
                calib = 0;
                calib_off = $urandom_range(6) + 1;
            end
            maint_ack  = ($urandom_range(2) == 0);
            softmc_fin = ($urandom_range(3) == 0);
            cycle();
        end
        cfg_valid = 0; maint_ack = 0; softmc_fin = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
